// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access width codes,
// FSM state encoding and the latched load context used to format load data.
package dmem_responder_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  typedef enum logic {IDLE, WAIT} dmem_state_t;

  typedef struct packed {
    logic [1:0] lsb;
    logic [1:0] width;
    logic       ext;
  } dmem_ld_ctx_t;

  // Right-align the addressed byte/half of a raw SRAM word, then extend it.
  function automatic logic [31:0] fmt_load(input logic [31:0] raw, input dmem_ld_ctx_t c);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = raw;
    res = raw;
    case (c.width)
      MEM_WIDTH_BYTE: begin
        sh  = raw >> {c.lsb, 3'b000};
        res = {{24{c.ext & sh[7]}}, sh[7:0]};
      end
      MEM_WIDTH_HALF: begin
        sh  = raw >> {c.lsb[1], 4'b0000};
        res = {{16{c.ext & sh[15]}}, sh[15:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous SRAM, 32-bit words with byte enables. The read port
// is registered and only updates when read-enabled, so it holds between loads.
module dmem_sram #(
  parameter int unsigned DEPTH = 4096,
  parameter int          AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable wait states in front of dmem_sram.
// Define DMEM_RANGE_CHECK_EN to flag out-of-window addresses with o_error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_write,
  input  logic [31:0] i_data_out,
  input  logic        i_extend,
  input  logic [1:0]  i_width,
  output logic        o_ack,
  output logic        o_error,
  output logic [31:0] o_data_in
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  dmem_state_t  r_state, w_state_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic         w_ack;
  logic [31:0]  w_off;
  logic [AW-1:0] w_idx;
  logic         w_in_range;
  logic         w_mis;
  logic         w_we, w_re;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata;
  logic [31:0]  w_rdata;
  logic         r_vld, r_zero;
  dmem_ld_ctx_t r_ctx;
  logic         w_unused;

  // Address decode; BASE_ADDR is window-aligned so the offset's low bits equal addr's.
  assign w_off = i_addr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];
  assign w_unused = ^{w_off[1:0], w_off[31:AW+2]};

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  assign w_in_range = (w_off < SPAN);
`else
  assign w_in_range = 1'b1;
`endif

  // Reset gates ack so a request caught by reset can never commit.
  assign w_ack   = reset_n & i_req & (r_cnt == WS);
  assign o_ack   = w_ack;
  assign o_error = w_ack & ~w_in_range;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_req && !w_ack) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      WAIT: begin
        if (!i_req || w_ack) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_mis = ((i_width == MEM_WIDTH_HALF) && i_addr[0]) ||
                 ((i_width[1] == 1'b1) && (i_addr[1:0] != 2'b00));

  // Store lanes: narrow data is replicated so the byte enables pick the lane.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_data_out;
    case (i_width)
      MEM_WIDTH_BYTE: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_data_out[7:0]}};
      end
      MEM_WIDTH_HALF: begin
        w_be    = 4'b0011 << {i_addr[1], 1'b0};
        w_wdata = {2{i_data_out[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_data_out;
      end
    endcase
  end

  assign w_we = w_ack &  i_write & w_in_range & ~w_mis;
  assign w_re = w_ack & ~i_write & w_in_range;

  dmem_sram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .i_re    (w_re),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Load context is captured on load acks and on any errored ack; in-range
  // stores leave it (and therefore o_data_in) untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld  <= 1'b0;
      r_zero <= 1'b0;
      r_ctx  <= '0;
    end else if (w_ack && (!i_write || !w_in_range)) begin
      r_vld       <= 1'b1;
      r_zero      <= ~w_in_range;
      r_ctx.lsb   <= i_addr[1:0];
      r_ctx.width <= i_width;
      r_ctx.ext   <= i_extend;
    end
  end

  assign o_data_in = (r_vld && !r_zero) ? fmt_load(w_rdata, r_ctx) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan steps followed by random
// accesses, all checked against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int unsigned WS    = 2;
  localparam logic [31:0] A     = 32'h0001_0010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        write = 1'b0;
  logic [31:0] dout = '0;
  logic        extend = 1'b0;
  logic [1:0]  width = '0;
  logic        ack, error;
  logic [31:0] din;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (req),
    .i_addr     (addr),
    .i_write    (write),
    .i_data_out (dout),
    .i_extend   (extend),
    .i_width    (width),
    .o_ack      (ack),
    .o_error    (error),
    .o_data_in  (din)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_din = '0;
  bit          din_known = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] lsb,
                                         input logic [1:0] w, input logic ext);
    logic [31:0] v;
    if (w == 2'd0) begin
      v = (word >> (8 * lsb)) & 32'hFF;
      if (ext && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = (word >> (16 * lsb[1])) & 32'hFFFF;
      if (ext && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // One request: waits for ack (bounded), checks latency and error, updates the model.
  task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] d,
                        input logic [1:0] w, input logic ext);
    int          lat;
    bit          got, oor, mis;
    logic [31:0] off, m, v;
    int unsigned idx;
    @(negedge clk);
    if (din_known) chk("data_in", din, exp_din);
    req = 1'b1; addr = a; write = wr; dout = d; width = w; extend = ext;
    lat = 0; got = 1'b0;
    while (!got && lat <= int'(WS) + 3) begin
      #1;
      if (ack) got = 1'b1;
      else begin
        lat++;
        @(negedge clk);
      end
    end
    chk("ack_latency", 32'(lat), 32'(WS));
    if (!got) begin
      req = 1'b0;
      return;
    end
    off = a - BASE;
`ifdef DMEM_RANGE_CHECK_EN
    oor = (off >= DEPTH * 4);
`else
    oor = 1'b0;
`endif
    chk("error", {31'd0, error}, {31'd0, oor});
    idx = (off >> 2) % DEPTH;
    mis = (w == 2'd1 && a[0]) || (w >= 2'd2 && a[1:0] != 2'd0);
    if (oor) begin
      exp_din = '0;
      din_known = 1'b1;
    end else if (wr) begin
      if (!mis) begin
        if (w == 2'd0) begin
          m = 32'hFF << (8 * a[1:0]);
          v = (d & 32'hFF) << (8 * a[1:0]);
        end else if (w == 2'd1) begin
          m = 32'hFFFF << (16 * a[1]);
          v = (d & 32'hFFFF) << (16 * a[1]);
        end else begin
          m = 32'hFFFF_FFFF;
          v = d;
        end
        mem_m[idx] = (mem_m[idx] & ~m) | (v & m);
      end
    end else if (mis) begin
      din_known = 1'b0;
    end else begin
      exp_din = m_load(mem_m[idx], a[1:0], w, ext);
      din_known = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    if (din_known) chk("data_in_idle", din, exp_din);
    req = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_din(input string tag, input logic [31:0] v);
    @(negedge clk);
    req = 1'b0;
    chk(tag, din, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, off;
    logic [1:0]  w;

    // Reset with a request pending: nothing may be acked.
    req = 1'b1; addr = A; write = 1'b0; width = 2'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_data_in", din, 32'd0);
    reset_n = 1'b1; req = 1'b0;
    @(posedge clk);

    for (int i = 0; i < int'(DEPTH); i++) access(BASE + 32'(4 * i), 1'b1, $urandom, 2'd2, 1'b0);

    access(A, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0);
    access(A, 1'b0, 32'd0, 2'd2, 1'b0);
    expect_din("word_load", 32'hDEAD_BEEF);
    access(A + 1, 1'b0, 32'd0, 2'd0, 1'b1);
    expect_din("byte_sext", 32'hFFFF_FFBE);
    access(A + 1, 1'b0, 32'd0, 2'd0, 1'b0);
    expect_din("byte_zext", 32'h0000_00BE);
    access(A + 2, 1'b1, 32'h0000_1234, 2'd1, 1'b0);
    access(A, 1'b0, 32'd0, 2'd2, 1'b0);
    expect_din("half_merge", 32'h1234_BEEF);
    access(A + 1, 1'b1, 32'd0, 2'd2, 1'b0);
    access(A, 1'b0, 32'd0, 2'd2, 1'b0);
    expect_din("misaligned_store", 32'h1234_BEEF);

    access(32'h0000_0000, 1'b0, 32'd0, 2'd2, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
    expect_din("oor_load", 32'd0);
`else
    expect_din("alias_load", mem_m[0]);
`endif

    // Back-to-back: second request starts in the cycle after the first ack.
    access(A, 1'b0, 32'd0, 2'd0, 1'b1);
    access(A + 2, 1'b0, 32'd0, 2'd1, 1'b0);
    access(A, 1'b0, 32'd0, 2'd2, 1'b0);

    // Withdrawal after one wait cycle of a store.
    @(negedge clk);
    req = 1'b1; addr = A; write = 1'b1; dout = 32'hFFFF_FFFF; width = 2'd2;
    @(negedge clk);
    #1;
    chk("withdraw_noack", {31'd0, ack}, 32'd0);
    req = 1'b0;
    @(posedge clk);
    access(A, 1'b0, 32'd0, 2'd2, 1'b0);
    expect_din("withdraw_mem", 32'h1234_BEEF);

    // Reset mid-wait of a store.
    @(negedge clk);
    req = 1'b1; addr = A; write = 1'b1; dout = 32'h0; width = 2'd2;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    chk("midrst_data_in", din, 32'd0);
    req = 1'b0;
    reset_n = 1'b1;
    exp_din = '0;
    din_known = 1'b1;
    @(posedge clk);
    access(A, 1'b0, 32'd0, 2'd2, 1'b0);
    expect_din("rst_mem", 32'h1234_BEEF);

    for (int k = 0; k < 200; k++) begin
      off = 32'($urandom_range(DEPTH * 4 - 1, 0));
      a = ($urandom_range(9, 0) == 0) ? $urandom : BASE + off;
      w = 2'($urandom_range(3, 0));
      if ($urandom_range(3, 0) != 0) begin
        if (w == 2'd1) a[0] = 1'b0;
        else if (w >= 2'd2) a[1:0] = 2'b00;
      end
      access(a, 1'($urandom_range(1, 0)), $urandom, w, 1'($urandom_range(1, 0)));
      if ($urandom_range(4, 0) == 0) idle($urandom_range(2, 0));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
